// File: rtl/data_mem_responder.sv
// Word-addressed RAM answering byte/half/word loads and stores from a core, with misalignment detection.
// Latency: o_ready one cycle after WAIT_CYCLES edges past accept; no backpressure, requests are ignored while busy.
module data_mem_responder #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_memReq,
   input  logic        i_memWrite,
   input  logic [2:0]  i_funct3,
   input  logic        i_isLoadSigned,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_ready,
   output logic        o_err,
   output logic        o_busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] WC_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t        state, state_nxt;
   logic [3:0]    cnt, cnt_nxt;
   logic          accept;
   logic          enter_resp;

   logic          req_write;
   logic [1:0]    req_size;
   logic          req_signed;
   logic [AW+1:0] req_addr;
   logic [31:0]   req_wdata;

   logic          cur_write;
   logic [1:0]    cur_size;
   logic          cur_signed;
   logic [AW+1:0] cur_addr;
   logic [31:0]   cur_wdata;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] idx;
   logic [1:0]    lane;
   logic          cur_err;
   logic [3:0]    be;
   logic [31:0]   wword;
   logic [31:0]   shifted;
   logic [31:0]   load_val;

   logic unused;
   assign unused = ^{i_funct3[2], i_addr[31:AW+2]};

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_memReq) begin
               accept    = 1'b1;
               cnt_nxt   = '0;
               state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            if (cnt == WC_LAST) state_nxt = S_RESP;
            else                cnt_nxt   = cnt + 4'd1;
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         req_write  <= 1'b0;
         req_size   <= '0;
         req_signed <= 1'b0;
         req_addr   <= '0;
         req_wdata  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            req_write  <= i_memWrite;
            req_size   <= i_funct3[1:0];
            req_signed <= i_isLoadSigned;
            req_addr   <= i_addr[AW+1:0];
            req_wdata  <= i_wdata;
         end
      end
   end

   // With zero wait states RESP is entered on the accept edge, before the latch holds the request.
   always_comb begin
      cur_write  = req_write;
      cur_size   = req_size;
      cur_signed = req_signed;
      cur_addr   = req_addr;
      cur_wdata  = req_wdata;
      if (state == S_IDLE) begin
         cur_write  = i_memWrite;
         cur_size   = i_funct3[1:0];
         cur_signed = i_isLoadSigned;
         cur_addr   = i_addr[AW+1:0];
         cur_wdata  = i_wdata;
      end
   end

   assign enter_resp = !i_rst && (state_nxt == S_RESP);
   assign idx        = cur_addr[AW+1:2];
   assign lane       = cur_addr[1:0];
   assign cur_err    = (cur_size == 2'b11) ||
                       (cur_size == 2'b01 && lane[0]) ||
                       (cur_size == 2'b10 && lane != 2'b00);
   assign shifted    = mem[idx] >> {lane, 3'b000};

   always_comb begin
      be       = 4'b1111;
      wword    = cur_wdata;
      load_val = shifted;
      case (cur_size)
         2'b00: begin
            be       = 4'b0001 << lane;
            wword    = {4{cur_wdata[7:0]}};
            load_val = {{24{cur_signed & shifted[7]}}, shifted[7:0]};
         end
         2'b01: begin
            be       = lane[1] ? 4'b1100 : 4'b0011;
            wword    = {2{cur_wdata[15:0]}};
            load_val = {{16{cur_signed & shifted[15]}}, shifted[15:0]};
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (enter_resp && cur_write && !cur_err) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][b*8 +: 8] <= wword[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rdata <= '0;
         o_err   <= 1'b0;
      end else if (enter_resp) begin
         o_rdata <= (cur_write || cur_err) ? 32'd0 : load_val;
         o_err   <= cur_err;
      end else begin
         o_rdata <= '0;
         o_err   <= 1'b0;
      end
   end

   assign o_ready = (state == S_RESP);
   assign o_busy  = (state != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with WAIT_CYCLES=2: latency, lane handling, errors, reset behaviour.
module tb_data_mem_responder;

   logic        i_clk;
   logic        i_rst;
   logic        i_memReq;
   logic        i_memWrite;
   logic [2:0]  i_funct3;
   logic        i_isLoadSigned;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic [31:0] o_rdata;
   logic        o_ready;
   logic        o_err;
   logic        o_busy;

   int n_pass  = 0;
   int n_total = 0;

   data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_memReq       (i_memReq),
      .i_memWrite     (i_memWrite),
      .i_funct3       (i_funct3),
      .i_isLoadSigned (i_isLoadSigned),
      .i_addr         (i_addr),
      .i_wdata        (i_wdata),
      .o_rdata        (o_rdata),
      .o_ready        (o_ready),
      .o_err          (o_err),
      .o_busy         (o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // One request; lat counts negedges after the accept edge until o_ready is seen (20 = timeout).
   task automatic do_req(input logic wr, input logic [2:0] f3, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat,
                         output logic bsy);
      @(negedge i_clk);
      i_memWrite     = wr;
      i_funct3       = f3;
      i_isLoadSigned = sgn;
      i_addr         = a;
      i_wdata        = wd;
      i_memReq       = 1'b1;
      @(negedge i_clk);
      i_memReq = 1'b0;
      bsy = o_busy;
      lat = 1;
      while (!o_ready && lat < 20) begin
         @(negedge i_clk);
         lat++;
      end
      rd = o_rdata;
      er = o_err;
      @(negedge i_clk);
   endtask

   task automatic test_reset;
      i_rst = 1'b1;
      repeat (2) @(negedge i_clk);
      n_total++;
      if (o_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", o_ready);
      else n_pass++;
      n_total++;
      if (o_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", o_err);
      else n_pass++;
      n_total++;
      if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", o_busy);
      else n_pass++;
      n_total++;
      if (o_rdata !== 32'd0) $display("FAIL reset_rdata: got %h expected 00000000", o_rdata);
      else n_pass++;
      i_rst = 1'b0;
   endtask

   task automatic test_word;
      logic [31:0] rd; logic er; int lat; logic bsy;
      do_req(1'b1, 3'b010, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, bsy);
      n_total++;
      if (lat !== 3) $display("FAIL sw_latency: got %0d expected 3", lat);
      else n_pass++;
      n_total++;
      if (bsy !== 1'b1) $display("FAIL sw_busy_wait: got %b expected 1", bsy);
      else n_pass++;
      n_total++;
      if (rd !== 32'd0 || er !== 1'b0) $display("FAIL sw_resp: got rdata %h err %b expected 00000000 0", rd, er);
      else n_pass++;
      do_req(1'b0, 3'b010, 1'b0, 32'h10, 32'h0, rd, er, lat, bsy);
      n_total++;
      if (lat !== 3) $display("FAIL lw_latency: got %0d expected 3", lat);
      else n_pass++;
      n_total++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL lw_0x10: got rdata %h err %b expected deadbeef 0", rd, er);
      else n_pass++;
   endtask

   task automatic test_byte;
      logic [31:0] rd; logic er; int lat; logic bsy;
      do_req(1'b0, 3'b000, 1'b1, 32'h13, 32'h0, rd, er, lat, bsy);
      n_total++;
      if (rd !== 32'hFFFFFFDE) $display("FAIL lb_0x13: got %h expected ffffffde", rd);
      else n_pass++;
      do_req(1'b0, 3'b100, 1'b0, 32'h13, 32'h0, rd, er, lat, bsy);
      n_total++;
      if (rd !== 32'h000000DE) $display("FAIL lbu_0x13: got %h expected 000000de", rd);
      else n_pass++;
      do_req(1'b0, 3'b100, 1'b0, 32'h11, 32'h0, rd, er, lat, bsy);
      n_total++;
      if (rd !== 32'h000000BE) $display("FAIL lbu_0x11: got %h expected 000000be", rd);
      else n_pass++;
   endtask

   task automatic test_half;
      logic [31:0] rd; logic er; int lat; logic bsy;
      do_req(1'b1, 3'b001, 1'b0, 32'h12, 32'hAAAA1234, rd, er, lat, bsy);
      n_total++;
      if (er !== 1'b0 || lat !== 3) $display("FAIL sh_0x12: got err %b lat %0d expected 0 3", er, lat);
      else n_pass++;
      do_req(1'b0, 3'b010, 1'b0, 32'h10, 32'h0, rd, er, lat, bsy);
      n_total++;
      if (rd !== 32'h1234BEEF) $display("FAIL lw_after_sh: got %h expected 1234beef", rd);
      else n_pass++;
      do_req(1'b0, 3'b001, 1'b1, 32'h12, 32'h0, rd, er, lat, bsy);
      n_total++;
      if (rd !== 32'h00001234) $display("FAIL lh_0x12: got %h expected 00001234", rd);
      else n_pass++;
      do_req(1'b0, 3'b001, 1'b1, 32'h10, 32'h0, rd, er, lat, bsy);
      n_total++;
      if (rd !== 32'hFFFFBEEF) $display("FAIL lh_0x10: got %h expected ffffbeef", rd);
      else n_pass++;
   endtask

   task automatic test_misaligned;
      logic [31:0] rd; logic er; int lat; logic bsy;
      do_req(1'b0, 3'b001, 1'b1, 32'h11, 32'h0, rd, er, lat, bsy);
      n_total++;
      if (er !== 1'b1 || rd !== 32'd0 || lat !== 3) $display("FAIL lh_0x11: got err %b rdata %h lat %0d expected 1 00000000 3", er, rd, lat);
      else n_pass++;
      do_req(1'b1, 3'b010, 1'b0, 32'h12, 32'h0, rd, er, lat, bsy);
      n_total++;
      if (er !== 1'b1 || rd !== 32'd0) $display("FAIL sw_0x12: got err %b rdata %h expected 1 00000000", er, rd);
      else n_pass++;
      do_req(1'b0, 3'b011, 1'b0, 32'h10, 32'h0, rd, er, lat, bsy);
      n_total++;
      if (er !== 1'b1 || rd !== 32'd0) $display("FAIL size11: got err %b rdata %h expected 1 00000000", er, rd);
      else n_pass++;
      do_req(1'b0, 3'b010, 1'b0, 32'h10, 32'h0, rd, er, lat, bsy);
      n_total++;
      if (rd !== 32'h1234BEEF || er !== 1'b0) $display("FAIL lw_after_bad_sw: got rdata %h err %b expected 1234beef 0", rd, er);
      else n_pass++;
      do_req(1'b0, 3'b010, 1'b0, 32'h1010, 32'h0, rd, er, lat, bsy);
      n_total++;
      if (rd !== 32'h1234BEEF) $display("FAIL lw_wrap: got %h expected 1234beef", rd);
      else n_pass++;
   endtask

   task automatic test_reset_wait;
      logic [31:0] rd; logic er; int lat; logic bsy; logic seen;
      do_req(1'b1, 3'b010, 1'b0, 32'h20, 32'h11112222, rd, er, lat, bsy);
      @(negedge i_clk);
      i_memWrite = 1'b1;
      i_funct3   = 3'b010;
      i_addr     = 32'h20;
      i_wdata    = 32'h55;
      i_memReq   = 1'b1;
      @(negedge i_clk);
      i_memReq = 1'b0;
      i_rst    = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      n_total++;
      if (o_busy !== 1'b0 || o_ready !== 1'b0) $display("FAIL rst_wait_state: got busy %b ready %b expected 0 0", o_busy, o_ready);
      else n_pass++;
      seen = 1'b0;
      repeat (4) begin
         @(negedge i_clk);
         if (o_ready) seen = 1'b1;
      end
      n_total++;
      if (seen !== 1'b0) $display("FAIL rst_wait_ready: got ready pulse 1 expected 0");
      else n_pass++;
      do_req(1'b0, 3'b010, 1'b0, 32'h20, 32'h0, rd, er, lat, bsy);
      n_total++;
      if (rd !== 32'h11112222) $display("FAIL rst_wait_nostore: got %h expected 11112222", rd);
      else n_pass++;
      // Request raised on the same edge as reset must be dropped.
      @(negedge i_clk);
      i_memWrite = 1'b0;
      i_memReq   = 1'b1;
      i_rst      = 1'b1;
      @(negedge i_clk);
      i_memReq = 1'b0;
      i_rst    = 1'b0;
      @(negedge i_clk);
      n_total++;
      if (o_busy !== 1'b0) $display("FAIL rst_priority: got busy %b expected 0", o_busy);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      logic [31:0] acc_addr [3];
      logic [31:0] exp_data [3];
      logic        exp_rdy;
      acc_addr[0] = 32'h10; exp_data[0] = 32'h1234BEEF;
      acc_addr[1] = 32'h20; exp_data[1] = 32'h11112222;
      acc_addr[2] = 32'h10; exp_data[2] = 32'h1234BEEF;
      i_memWrite     = 1'b0;
      i_funct3       = 3'b010;
      i_isLoadSigned = 1'b0;
      for (int t = 0; t <= 12; t++) begin
         @(negedge i_clk);
         if (t > 0) begin
            exp_rdy = (t % 4 == 3);
            n_total++;
            if (o_ready !== exp_rdy) $display("FAIL b2b_ready_t%0d: got %b expected %b", t, o_ready, exp_rdy);
            else n_pass++;
            if (exp_rdy) begin
               n_total++;
               if (o_rdata !== exp_data[t/4]) $display("FAIL b2b_rdata_t%0d: got %h expected %h", t, o_rdata, exp_data[t/4]);
               else n_pass++;
            end
         end
         if (t < 12) begin
            i_memReq = 1'b1;
            if (t % 4 == 0) i_addr = acc_addr[t/4];
            else            i_addr = (acc_addr[t/4] == 32'h10) ? 32'h20 : 32'h10;
         end else begin
            i_memReq = 1'b0;
         end
      end
   endtask

   initial begin
      i_rst          = 1'b1;
      i_memReq       = 1'b0;
      i_memWrite     = 1'b0;
      i_funct3       = 3'b000;
      i_isLoadSigned = 1'b0;
      i_addr         = 32'h0;
      i_wdata        = 32'h0;
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_misaligned();
      test_reset_wait();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
